vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Owns the single-port 12-bit frame RAM (640x480, one word per pixel) and shares it between two requesters.
- The VGA display read path has absolute priority whenever the display driver asserts its active-low read strobe.
- Pixel writes from game logic are queued in a small write FIFO and drained only on cycles the display is not reading.
- A clear-screen sequencer fills the whole buffer with one colour, also using non-display cycles only.

Parameters:
- FIFO_DEPTH, 4, write-queue entries (power of two, >=2)
- H_PIX, 640, visible columns
- V_PIX, 480, visible rows
- ADDR_W, 19, RAM address width (ceil log2 of H_PIX*V_PIX)

Ports:
- clk_25mHz  in  1  pixel clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- vga_rdn  in  1  display read strobe from VGA driver, 0 = read this cycle
- vga_row  in  9  display pixel row
- vga_col  in  10  display pixel column
- vga_din  out  12  pixel data to VGA driver, {B,G,R} 4 bits each
- wr_valid  in  1  writer has a pixel
- wr_ready  out  1  FIFO can accept
- wr_row  in  9  write row
- wr_col  in  10  write column
- wr_data  in  12  write colour
- wr_drop  out  1  one-cycle pulse: accepted write was out of range and discarded
- clr_start  in  1  pulse: begin clear-screen
- clr_color  in  12  fill colour, sampled on clr_start
- clr_busy  out  1  clear in progress
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  12  RAM write data
- mem_rdata  in  12  RAM read data, synchronous RAM, 1-cycle latency

Behaviour:
- Address mapping: addr = row*640 + col, computed as (row<<9)+(row<<7)+col in ADDR_W bits. No multiplier.
- Reset (rst_n=0 at an edge): FIFO emptied, FSM to IDLE, clr_busy=0, wr_drop=0, mem_we=0, mem_addr=0, mem_wdata=0, wr_ready=1 on the following cycle.
- Priority each cycle: display read > clear sweep > FIFO drain.
- Display read: when vga_rdn=0, mem_addr = map(vga_row,vga_col) combinationally and mem_we=0. vga_din = mem_rdata (pass-through), valid one cycle after the address.
- Handshake: transfer occurs when wr_valid & wr_ready at a clock edge.
  - wr_ready = FIFO not full. It is registered from the occupancy count; a pop does not free a slot in the same cycle.
  - Out-of-range writes (row>=480 or col>=640) are accepted but not enqueued. wr_drop pulses high the following cycle.
- Drain: in FSM IDLE, if vga_rdn=1 and the FIFO is non-empty, pop the head and drive mem_we=1, mem_addr=map(head), mem_wdata=head data. One pop per cycle.
- Push and pop in the same cycle are both allowed (count unchanged).
- FSM states:
  - IDLE: clr_start=1 -> latch clr_color, clr_ptr=0, go to CLEAR, clr_busy=1 next cycle.
  - CLEAR: on each cycle with vga_rdn=1, write clr_color at clr_ptr, then clr_ptr++. After writing address H_PIX*V_PIX-1, go to IDLE and clear clr_busy.
  - CLEAR with vga_rdn=0: stall, pointer held.
  - clr_start while already in CLEAR: ignored.
  - FIFO keeps accepting during CLEAR but does not drain until IDLE.
- Ordering: queued writes made before clr_start that are still pending drain after the clear completes, so they overwrite the fill. This is intended.
- Reset mid-clear: sweep aborted, clr_busy=0, RAM contents left partially filled.

Decomposition:
- Shared package `vga_pkg`:
  - constants H_PIX, V_PIX, ADDR_W
  - pixel colour width (12)
  - function/macro for row/col -> address mapping
  - FSM state encoding {IDLE, CLEAR}
- One natural sub-module: `pix_fifo`, a synchronous FIFO carrying {addr, data}, with push/pop/full/empty/count.
  - Address mapping is done before enqueue, so entries are ADDR_W+12 bits.

Test Plan:
- Display priority: vga_rdn=0, row=1, col=2, with a FIFO entry pending -> mem_addr=642, mem_we=0, no pop. vga_din equals the RAM word one cycle later.
- Drain in blanking: vga_rdn=1, push (row=479, col=639, data=12'hABC) -> one cycle after enqueue, mem_we=1, mem_addr=307199, mem_wdata=12'hABC.
- Backpressure: hold vga_rdn=0, push 4 writes -> wr_ready=0 after the 4th. 5th wr_valid not accepted. Release vga_rdn -> 4 consecutive writes in order.
- Out-of-range: push row=480, col=0 -> wr_drop=1 for one cycle, no mem_we, FIFO count unchanged.
- Clear: clr_start with clr_color=12'h0F0, vga_rdn=1 throughout -> clr_busy high for exactly 307200 cycles, writes to addrs 0..307199 with data 12'h0F0. With vga_rdn toggled 50%, the sweep stretches and no write occurs on vga_rdn=0 cycles.
- Reset mid-clear: rst_n=0 at clr_ptr=1000 -> next cycle clr_busy=0, mem_we=0, wr_ready=1, FIFO empty.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants, FSM encoding and pixel address mapping for the VRAM arbiter.
package vga_pkg;

  localparam int H_PIX  = 640;
  localparam int V_PIX  = 480;
  localparam int ADDR_W = 19;
  localparam int PIX_W  = 12;

  // Arbiter FSM encoding
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // row*640 + col built from shifts so no multiplier is inferred
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [8:0] row, input logic [9:0] col);
    logic [ADDR_W-1:0] r_ext;
    logic [ADDR_W-1:0] c_ext;
    r_ext = {{(ADDR_W-9){1'b0}}, row};
    c_ext = {{(ADDR_W-10){1'b0}}, col};
    return (r_ext << 9) + (r_ext << 7) + c_ext;
  endfunction

endpackage

// File: rtl/pix_fifo.sv
// Small synchronous FIFO holding pre-mapped {addr, data} pixel writes.
module pix_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 31,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count_nxt
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == {CW{1'b0}});
  assign dout      = mem_q[rd_ptr_q];
  assign count_nxt = count_d;

  // Next pointer and occupancy; overflow/underflow requests are ignored
  always_comb begin
    do_push_s = push & ~full;
    do_pop_s  = pop & ~empty;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because occupancy gates reads
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Frame RAM arbiter: display reads first, then clear sweep, then queued pixel writes.
module vram_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int H_PIX      = 640,
  parameter int V_PIX      = 480,
  parameter int ADDR_W     = 19
) (
  input  logic              clk_25mHz,
  input  logic              rst_n,
  input  logic              vga_rdn,
  input  logic [8:0]        vga_row,
  input  logic [9:0]        vga_col,
  output logic [11:0]       vga_din,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [8:0]        wr_row,
  input  logic [9:0]        wr_col,
  input  logic [11:0]       wr_data,
  output logic              wr_drop,
  input  logic              clr_start,
  input  logic [11:0]       clr_color,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [11:0]       mem_wdata,
  input  logic [11:0]       mem_rdata
);

  import vga_pkg::*;

  localparam int                CW       = $clog2(FIFO_DEPTH) + 1;
  localparam int                EW       = ADDR_W + PIX_W;
  localparam logic [8:0]        ROW_LIM  = 9'(V_PIX);
  localparam logic [9:0]        COL_LIM  = 10'(H_PIX);
  localparam logic [CW-1:0]     FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(H_PIX * V_PIX - 1);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [PIX_W-1:0]  clr_color_q, clr_color_d;
  logic              wr_ready_q, wr_ready_d;
  logic              wr_drop_q, wr_drop_d;

  logic              in_range_s;
  logic              accept_s;
  logic              push_s;
  logic              pop_s;
  logic [EW-1:0]     fifo_din_s;
  logic [EW-1:0]     fifo_dout_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [CW-1:0]     fifo_cnt_nxt_s;

  // Read data is a plain pass-through of the synchronous RAM output
  assign vga_din  = mem_rdata;
  assign wr_ready = wr_ready_q;
  assign wr_drop  = wr_drop_q;
  assign clr_busy = (state_q == ST_CLEAR);

  // Map the write coordinate before queueing so the drain path needs no adder
  assign fifo_din_s = {pix_addr(wr_row, wr_col), wr_data};

  pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk       (clk_25mHz),
    .rst_n     (rst_n),
    .push      (push_s),
    .pop       (pop_s),
    .din       (fifo_din_s),
    .dout      (fifo_dout_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count_nxt (fifo_cnt_nxt_s)
  );

  // Writer handshake: out-of-range pixels are accepted and discarded; ready tracks next occupancy
  always_comb begin
    in_range_s = (wr_row < ROW_LIM) && (wr_col < COL_LIM);
    accept_s   = wr_valid & wr_ready_q;
    push_s     = accept_s & in_range_s & ~fifo_full_s;
    wr_drop_d  = accept_s & ~in_range_s;
    wr_ready_d = (fifo_cnt_nxt_s != FULL_CNT);
  end

  // RAM port arbitration and clear-sweep sequencing
  always_comb begin
    mem_we      = 1'b0;
    mem_addr    = {ADDR_W{1'b0}};
    mem_wdata   = {PIX_W{1'b0}};
    pop_s       = 1'b0;
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    clr_color_d = clr_color_q;
    if (!vga_rdn) begin
      mem_addr = pix_addr(vga_row, vga_col);
    end else if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_addr  = clr_ptr_q;
      mem_wdata = clr_color_q;
      if (clr_ptr_q == CLR_LAST) begin
        state_d   = ST_IDLE;
        clr_ptr_d = {ADDR_W{1'b0}};
      end else begin
        clr_ptr_d = clr_ptr_q + 1'b1;
      end
    end else if (!fifo_empty_s) begin
      pop_s     = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = fifo_dout_s[EW-1:PIX_W];
      mem_wdata = fifo_dout_s[PIX_W-1:0];
    end else begin
      mem_we = 1'b0;
    end
    // A start request is only honoured from IDLE; during a sweep it is ignored
    if ((state_q == ST_IDLE) && clr_start) begin
      state_d     = ST_CLEAR;
      clr_ptr_d   = {ADDR_W{1'b0}};
      clr_color_d = clr_color;
    end else begin
      clr_color_d = clr_color_d;
    end
  end

  // Control registers; reset aborts any sweep in progress and leaves RAM as is
  always_ff @(posedge clk_25mHz) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      clr_ptr_q   <= {ADDR_W{1'b0}};
      clr_color_q <= {PIX_W{1'b0}};
      wr_ready_q  <= 1'b1;
      wr_drop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      clr_color_q <= clr_color_d;
      wr_ready_q  <= wr_ready_d;
      wr_drop_q   <= wr_drop_d;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench: full-size instance for arbitration, short-frame instance for sweeps.
module tb_vram_arbiter;

  logic clk_25mHz = 1'b0;
  always #20 clk_25mHz = ~clk_25mHz;

  logic        rst_n, vga_rdn, wr_valid, clr_start;
  logic [8:0]  vga_row, wr_row;
  logic [9:0]  vga_col, wr_col;
  logic [11:0] wr_data, clr_color;

  logic [11:0] vga_din, mem_wdata, mem_rdata;
  logic        wr_ready, wr_drop, clr_busy, mem_we;
  logic [18:0] mem_addr;

  logic [11:0] vga_din_s, mem_wdata_s, mem_rdata_s;
  logic        wr_ready_s, wr_drop_s, clr_busy_s, mem_we_s;
  logic [18:0] mem_addr_s;

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0] ram [0:307199];

  int bp_row [4] = '{0, 0, 2, 10};
  int bp_col [4] = '{0, 1, 3, 20};
  logic [11:0] bp_dat [4] = '{12'h111, 12'h222, 12'h333, 12'h444};

  vram_arbiter dut (
    .clk_25mHz(clk_25mHz), .rst_n(rst_n), .vga_rdn(vga_rdn), .vga_row(vga_row), .vga_col(vga_col),
    .vga_din(vga_din), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data), .wr_drop(wr_drop), .clr_start(clr_start), .clr_color(clr_color),
    .clr_busy(clr_busy), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  vram_arbiter #(.V_PIX(4)) dut_s (
    .clk_25mHz(clk_25mHz), .rst_n(rst_n), .vga_rdn(vga_rdn), .vga_row(vga_row), .vga_col(vga_col),
    .vga_din(vga_din_s), .wr_valid(wr_valid), .wr_ready(wr_ready_s), .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data), .wr_drop(wr_drop_s), .clr_start(clr_start), .clr_color(clr_color),
    .clr_busy(clr_busy_s), .mem_addr(mem_addr_s), .mem_we(mem_we_s), .mem_wdata(mem_wdata_s),
    .mem_rdata(mem_rdata_s)
  );

  // Synchronous single-port RAM model with one-cycle read latency
  always @(posedge clk_25mHz) begin
    if (mem_we && (mem_addr < 19'd307200)) ram[mem_addr] <= mem_wdata;
    if (mem_addr < 19'd307200) mem_rdata <= ram[mem_addr];
    else mem_rdata <= 12'h000;
  end
  assign mem_rdata_s = 12'h000;

  task automatic step();
    @(posedge clk_25mHz);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vga_rdn = 1'b1; vga_row = 9'd0; vga_col = 10'd0;
    wr_valid = 1'b0; wr_row = 9'd0; wr_col = 10'd0; wr_data = 12'h000;
    clr_start = 1'b0; clr_color = 12'h000;
    step(); step();
    n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL rst_wr_ready: got %b want 1", wr_ready); end
    n_cmp++; if (wr_drop !== 1'b0) begin n_bad++; $display("FAIL rst_wr_drop: got %b want 0", wr_drop); end
    n_cmp++; if (clr_busy !== 1'b0) begin n_bad++; $display("FAIL rst_clr_busy: got %b want 0", clr_busy); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    n_cmp++; if (mem_addr !== 19'd0) begin n_bad++; $display("FAIL rst_mem_addr: got %0d want 0", mem_addr); end
    n_cmp++; if (mem_wdata !== 12'h000) begin n_bad++; $display("FAIL rst_mem_wdata: got %h want 000", mem_wdata); end
    n_cmp++; if (clr_busy_s !== 1'b0) begin n_bad++; $display("FAIL rst_clr_busy_s: got %b want 0", clr_busy_s); end
    rst_n = 1'b1;
  endtask

  task automatic test_drain();
    step();
    vga_rdn = 1'b1; wr_valid = 1'b1; wr_row = 9'd479; wr_col = 10'd639; wr_data = 12'hABC;
    #1;
    n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL drain_ready: got %b want 1", wr_ready); end
    step();
    wr_valid = 1'b0; #1;
    n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL drain_we: got %b want 1", mem_we); end
    n_cmp++; if (mem_addr !== 19'd307199) begin n_bad++; $display("FAIL drain_addr: got %0d want 307199", mem_addr); end
    n_cmp++; if (mem_wdata !== 12'hABC) begin n_bad++; $display("FAIL drain_data: got %h want abc", mem_wdata); end
    step();
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL drain_once: got we=%b want 0", mem_we); end
  endtask

  task automatic test_priority();
    step();
    wr_valid = 1'b1; wr_row = 9'd1; wr_col = 10'd2; wr_data = 12'h5A5;
    vga_rdn = 1'b0; vga_row = 9'd1; vga_col = 10'd2;
    step();
    wr_valid = 1'b0; #1;
    n_cmp++; if (mem_addr !== 19'd642) begin n_bad++; $display("FAIL prio_addr: got %0d want 642", mem_addr); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL prio_we: got %b want 0", mem_we); end
    step();
    vga_rdn = 1'b1; #1;
    n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 19'd642 || mem_wdata !== 12'h5A5) begin
      n_bad++; $display("FAIL prio_no_pop: got we=%b addr=%0d data=%h want 1/642/5a5", mem_we, mem_addr, mem_wdata);
    end
    step();
    vga_rdn = 1'b0; #1;
    step();
    n_cmp++; if (vga_din !== 12'h5A5) begin n_bad++; $display("FAIL prio_rdata: got %h want 5a5", vga_din); end
    vga_row = 9'd479; vga_col = 10'd639;
    step();
    n_cmp++; if (vga_din !== 12'hABC) begin n_bad++; $display("FAIL prio_rdata_last: got %h want abc", vga_din); end
    vga_rdn = 1'b1; vga_row = 9'd0; vga_col = 10'd0;
  endtask

  task automatic test_backpressure();
    logic [18:0] exp_a;
    step();
    vga_rdn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_row = 9'(bp_row[i]); wr_col = 10'(bp_col[i]); wr_data = bp_dat[i];
      #1;
      n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_%0d: got %b want 1", i, wr_ready); end
      step();
    end
    n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full: got %b want 0", wr_ready); end
    wr_row = 9'd5; wr_col = 10'd5; wr_data = 12'h555;
    step(); step();
    n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL bp_still_full: got %b want 0", wr_ready); end
    wr_valid = 1'b0; vga_rdn = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      exp_a = 19'(bp_row[i] * 640 + bp_col[i]);
      n_cmp++; if (mem_we !== 1'b1 || mem_addr !== exp_a || mem_wdata !== bp_dat[i]) begin
        n_bad++; $display("FAIL bp_drain_%0d: got we=%b addr=%0d data=%h want 1/%0d/%h", i, mem_we, mem_addr, mem_wdata, exp_a, bp_dat[i]);
      end
      if (i == 0) begin
        n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_pop_cycle: got %b want 0", wr_ready); end
      end else if (i == 1) begin
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after_pop: got %b want 1", wr_ready); end
      end
      step();
    end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL bp_fifth_rejected: got we=%b want 0", mem_we); end
  endtask

  task automatic test_out_of_range();
    int oor_row [2] = '{480, 0};
    int oor_col [2] = '{0, 640};
    for (int i = 0; i < 2; i++) begin
      vga_rdn = 1'b1; wr_valid = 1'b1; wr_row = 9'(oor_row[i]); wr_col = 10'(oor_col[i]); wr_data = 12'hFFF;
      #1;
      n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL oor_ready_%0d: got %b want 1", i, wr_ready); end
      step();
      wr_valid = 1'b0; #1;
      n_cmp++; if (wr_drop !== 1'b1 || mem_we !== 1'b0) begin
        n_bad++; $display("FAIL oor_drop_%0d: got drop=%b we=%b want 1/0", i, wr_drop, mem_we);
      end
      step();
      n_cmp++; if (wr_drop !== 1'b0 || mem_we !== 1'b0) begin
        n_bad++; $display("FAIL oor_after_%0d: got drop=%b we=%b want 0/0", i, wr_drop, mem_we);
      end
    end
  endtask

  task automatic test_clear_full();
    int n;
    int bad;
    vga_rdn = 1'b1; clr_color = 12'h0F0; clr_start = 1'b1;
    step();
    clr_start = 1'b0; clr_color = 12'h000; #1;
    n_cmp++; if (clr_busy_s !== 1'b1) begin n_bad++; $display("FAIL clr_busy_start: got %b want 1", clr_busy_s); end
    n = 0; bad = 0;
    while (clr_busy_s === 1'b1 && n < 6000) begin
      if (mem_we_s !== 1'b1 || mem_addr_s !== 19'(n) || mem_wdata_s !== 12'h0F0) bad++;
      n++;
      step();
    end
    n_cmp++; if (n != 2560) begin n_bad++; $display("FAIL clr_busy_len: got %0d want 2560", n); end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL clr_sweep: got %0d bad cycles want 0", bad); end
    n_cmp++; if (mem_we_s !== 1'b0) begin n_bad++; $display("FAIL clr_done_we: got %b want 0", mem_we_s); end
  endtask

  task automatic test_clear_toggle();
    int n;
    int w;
    int bad;
    vga_row = 9'd3; vga_col = 10'd7; vga_rdn = 1'b1; clr_color = 12'hF00; clr_start = 1'b1;
    step();
    clr_start = 1'b0; clr_color = 12'h00F;
    n = 0; w = 0; bad = 0;
    while (clr_busy_s === 1'b1 && n < 12000) begin
      vga_rdn = (n % 2 == 0) ? 1'b1 : 1'b0;
      clr_start = (n == 101) ? 1'b1 : 1'b0;
      #1;
      if (vga_rdn == 1'b0) begin
        if (mem_we_s !== 1'b0 || mem_addr_s !== 19'd1927) bad++;
      end else begin
        if (mem_we_s !== 1'b1 || mem_addr_s !== 19'(w) || mem_wdata_s !== 12'hF00) bad++;
        w++;
      end
      n++;
      step();
    end
    clr_start = 1'b0; vga_rdn = 1'b1;
    n_cmp++; if (w != 2560) begin n_bad++; $display("FAIL clr_tog_writes: got %0d want 2560", w); end
    n_cmp++; if (n != 5119) begin n_bad++; $display("FAIL clr_tog_len: got %0d want 5119", n); end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL clr_tog_sweep: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_reset_mid_clear();
    vga_rdn = 1'b1; clr_color = 12'h0AA; clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      if (k == 10) begin
        wr_valid = 1'b1; wr_row = 9'd1; wr_col = 10'd1; wr_data = 12'h123;
      end else begin
        wr_valid = 1'b0;
      end
      step();
    end
    wr_valid = 1'b0; #1;
    n_cmp++; if (mem_addr_s !== 19'd1000 || mem_we_s !== 1'b1 || clr_busy_s !== 1'b1) begin
      n_bad++; $display("FAIL mid_ptr: got addr=%0d we=%b busy=%b want 1000/1/1", mem_addr_s, mem_we_s, clr_busy_s);
    end
    rst_n = 1'b0;
    step();
    n_cmp++; if (clr_busy_s !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b want 0", clr_busy_s); end
    n_cmp++; if (mem_we_s !== 1'b0) begin n_bad++; $display("FAIL mid_rst_we: got %b want 0", mem_we_s); end
    n_cmp++; if (wr_ready_s !== 1'b1) begin n_bad++; $display("FAIL mid_rst_ready: got %b want 1", wr_ready_s); end
    n_cmp++; if (mem_addr_s !== 19'd0) begin n_bad++; $display("FAIL mid_rst_addr: got %0d want 0", mem_addr_s); end
    rst_n = 1'b1;
    step();
    n_cmp++; if (mem_we_s !== 1'b0 || clr_busy_s !== 1'b0) begin
      n_bad++; $display("FAIL mid_fifo_empty: got we=%b busy=%b want 0/0", mem_we_s, clr_busy_s);
    end
  endtask

  initial begin
    test_reset();
    test_drain();
    test_priority();
    test_backpressure();
    test_out_of_range();
    test_clear_full();
    test_clear_toggle();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, want completion before 5ms");
    $fatal(1, "watchdog expired");
  end

endmodule
